pe_buf_arbiter: RTL
===================

Name: pe_buf_arbiter

Overview:
- Shares one single-port feature/weight SRAM among NUM_REQ requesters.
- Requester 0 is the PE array controller's streaming read port. Requesters 1..NUM_REQ-1 are the DMA loader and the host readback path.
- Supports burst locking, fixed-latency read-response routing and a lock-timeout.
- Sits between the requesters and the SRAM macro in the PE subsystem.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 16, SRAM address width
DATA_W, 128, SRAM data width (16 lanes x 8 bit)
MEM_LAT, 1, SRAM read latency in cycles from mem_en (1..4)
TIMEOUT, 64, idle cycles in LOCKED before forced release
STARVE_LIMIT, 32, used only with ARB_STARVE_GUARD_EN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accept (combinational)
req_we  in  NUM_REQ  1 = write beat, 0 = read beat
req_last  in  NUM_REQ  final beat of burst
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
rsp_valid  out  NUM_REQ  read data valid, one-hot
rsp_data  out  DATA_W  read data, shared by all requesters
mem_en  out  1  SRAM enable (registered)
mem_we  out  1  SRAM write enable (registered)
mem_addr  out  ADDR_W  SRAM address (registered)
mem_wdata  out  DATA_W  SRAM write data (registered)
mem_rdata  in  DATA_W  SRAM read data, valid MEM_LAT cycles after mem_en
busy  out  1  high in LOCKED or while any read is in flight
lock_err  out  1  one-cycle pulse on timeout release

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous, active-high.
- Reset values: all outputs 0. State IDLE, RR pointer 1, timeout counter 0, response tag pipeline cleared.
- Reset mid-operation: in-flight reads produce no rsp_valid.
- Accept: a beat is accepted at cycle T when req_valid[i] && req_ready[i].
  - mem_* reflect that beat at T+1.
  - Reads: rsp_valid[i] is high exactly at T+1+MEM_LAT. rsp_data is driven combinationally from mem_rdata.
- Non-accept: with no accept at T, mem_en=0 at T+1 and mem_we=0 at T+1.
- State IDLE:
  - Winner is requester 0 if it is valid.
  - Otherwise the first valid requester at or after the RR pointer, scanning 1..NUM_REQ-1 and wrapping.
  - req_ready is asserted only for the winner.
  - Accepted beat with req_last=1 stays in IDLE.
  - Accepted beat with req_last=0 goes to LOCKED, with owner = winner.
- State LOCKED:
  - req_ready = one-hot(owner) for the owner's valid. All other requesters see ready 0.
  - Accepted beat with req_last=1 returns to IDLE next cycle.
  - A beat while locked may be a read or a write. Mixed bursts are legal.
- RR pointer:
  - Updates when a burst by requester k>=1 completes (last beat accepted), to k+1, wrapping NUM_REQ-1 to 1.
  - Requester 0 bursts do not move it.
- Timeout:
  - In LOCKED, the counter increments each cycle the owner's req_valid is 0 and resets on an owner beat.
  - At TIMEOUT, go to IDLE and pulse lock_err for one cycle.
  - The counter does not run in IDLE.
- Simultaneous events:
  - Owner beat with last and a new request in the same cycle: the new request is arbitrated the following cycle in IDLE. There is no same-cycle regrant.
  - req_valid deasserted without acceptance is legal only in IDLE.
- Response routing: a NUM_REQ-bit one-hot tag shift register of depth 1+MEM_LAT. At most one bit is set per stage.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each IDLE cycle in which requester 0 wins while any requester >=1 is valid.
  - When it reaches STARVE_LIMIT, the next IDLE arbitration skips requester 0 and uses round-robin among 1..NUM_REQ-1.
  - The counter clears when a requester >=1 is granted.
- Undefined: strict priority for requester 0. The counter logic is absent.

Test Plan:
- Single read, MEM_LAT=1: requester 1 reads addr 0x0010 accepted at T -> mem_en=1, mem_addr=0x0010 at T+1; rsp_valid=3'b010 at T+2 with rsp_data=SRAM[0x10].
- Priority: requesters 0 and 2 valid in the same cycle, both single-beat -> requester 0 accepted first; requester 2 accepted the next cycle; RR pointer becomes 1 after requester 2.
- Burst lock: requester 1 writes 4 beats (last on beat 4) while requester 0 is valid throughout -> req_ready[0]=0 until beat 4 is accepted; requester 0 is granted the cycle after IDLE is re-entered.
- Timeout, TIMEOUT=64: requester 2 sends 1 beat with last=0, then drops valid -> lock_err pulses once 64 cycles later; requester 1 is then grantable.
- Reset mid-read: assert rst the cycle after a read accept -> no rsp_valid; all outputs 0 the next cycle.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT=32: requester 0 continuously valid with single beats and requester 1 valid -> requester 1 granted on the 33rd IDLE arbitration; never granted without the macro.

Source files
------------

// File: rtl/pe_buf_arbiter.sv
// Single-port PE buffer SRAM arbiter: requester 0 has priority, the rest share round-robin,
// with burst locking, lock timeout and fixed-latency read routing. Optional macro: ARB_STARVE_GUARD_EN.
//
// state   | meaning
// IDLE    | arbitrate every cycle; single-beat grants stay here
// LOCKED  | owner holds the SRAM until its last beat or the idle timeout
module pe_buf_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 128,
    parameter int MEM_LAT      = 1,
    parameter int TIMEOUT      = 64,
    parameter int STARVE_LIMIT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy,
    output logic                      lock_err
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic               timeout_hit;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     cand;
    logic               skip0;
    logic               accept;
    logic [IDX_W-1:0]   acc_idx;
    logic [NUM_REQ-1:0] acc_onehot;
    logic               tag_any;
    logic [NUM_REQ-1:0] tag [MEM_LAT+1];
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Requester 0 wins outright unless starved out; otherwise scan 1..NUM_REQ-1 from rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (req_valid[0] && !skip0) begin
            win_found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ - 1);
                if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand[IDX_W-1:0];
                end
            end
            if (!win_found && req_valid[0]) win_found = 1'b1;
        end
    end

    assign acc_onehot = req_valid & req_ready;
    assign accept     = |acc_onehot;
    assign acc_idx    = (state == S_IDLE) ? win_idx : owner;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_nxt      = rr_ptr;
        to_cnt_nxt  = to_cnt;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && !req_last[acc_idx]) begin
                    state_nxt  = S_LOCKED;
                    owner_nxt  = acc_idx;
                    to_cnt_nxt = '0;
                end
            end
            S_LOCKED: begin
                if (accept) begin
                    to_cnt_nxt = '0;
                    if (req_last[acc_idx]) state_nxt = S_IDLE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_nxt   = S_IDLE;
                    to_cnt_nxt  = '0;
                    timeout_hit = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (accept && req_last[acc_idx] && acc_idx != '0)
            rr_nxt = (acc_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : acc_idx + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= IDX_W'(1);
            to_cnt    <= '0;
            lock_err  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int k = 0; k <= MEM_LAT; k++) tag[k] <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            to_cnt   <= to_cnt_nxt;
            lock_err <= timeout_hit;
            mem_en   <= accept;
            mem_we   <= accept && req_we[acc_idx];
            if (accept) begin
                mem_addr  <= addr_arr[acc_idx];
                mem_wdata <= wdata_arr[acc_idx];
            end
            // Tag stage 0 lines up with mem_en; stage MEM_LAT lines up with mem_rdata.
            tag[0] <= acc_onehot & ~req_we;
            for (int k = 1; k <= MEM_LAT; k++) tag[k] <= tag[k-1];
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst) begin
            if (state == S_IDLE) begin
                if (win_found) req_ready[win_idx] = 1'b1;
            end else begin
                req_ready[owner] = req_valid[owner];
            end
        end
        tag_any = 1'b0;
        for (int k = 0; k <= MEM_LAT; k++) tag_any = tag_any | (|tag[k]);
        busy      = (state == S_LOCKED) || tag_any;
        rsp_valid = tag[MEM_LAT];
        rsp_data  = (|tag[MEM_LAT]) ? mem_rdata : '0;
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SV_W = $clog2(STARVE_LIMIT + 1);
    logic [SV_W-1:0] starve_cnt;

    assign skip0 = (starve_cnt == SV_W'(STARVE_LIMIT));

    // Once saturated, requester 0 can only win when nobody else is valid, so no increment then.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE && accept) begin
            if (acc_idx != '0)
                starve_cnt <= '0;
            else if (|req_valid[NUM_REQ-1:1])
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign skip0 = (STARVE_LIMIT < 0);
`endif

endmodule
